// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared constants for the RTC bus controller: register address map, FSM state
// encodings, default phase timings and the latched request record.
package rtc_pkg;

  localparam int unsigned TPULSE_DEF = 4;
  localparam int unsigned TGAP_DEF   = 4;

  // Index 0 is the rightmost element, so ADDR_MAP[dir] reads naturally.
  localparam logic [7:0][7:0] ADDR_MAP = {
    8'hF0,  // 7: command/transfer
    8'h26,  // 6: year
    8'h25,  // 5: month
    8'h24,  // 4: day
    8'h23,  // 3: hours
    8'h22,  // 2: minutes
    8'h21,  // 1: seconds
    8'h00   // 0: control
  };

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAddr = 3'd1;
  localparam logic [2:0] StGap1 = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StGap2 = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  typedef struct packed {
    logic       mod;
    logic [2:0] dir;
    logic [7:0] wdata;
  } rtc_req_t;

  function automatic logic [7:0] rtc_addr(input logic [2:0] dir);
    return ADDR_MAP[dir];
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// Menu-side request/response signals plus the RTC multiplexed bus pins.
interface rtc_bus_ctrl_if;
  logic       Acceso;
  logic       Mod;
  logic [2:0] DIR;
  logic [7:0] DATO_W;
  logic       FRW;
  logic       BUSY;
  logic [7:0] DATO_R;
  logic [2:0] DIR_R;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       AD_SEL;
  logic [7:0] AD_OUT;
  logic       AD_OE;
  logic [7:0] AD_IN;

  modport slave (
    input  Acceso, Mod, DIR, DATO_W, AD_IN,
    output FRW, BUSY, DATO_R, DIR_R, CS_n, RD_n, WR_n, AD_SEL, AD_OUT, AD_OE
  );

  modport master (
    output Acceso, Mod, DIR, DATO_W, AD_IN,
    input  FRW, BUSY, DATO_R, DIR_R, CS_n, RD_n, WR_n, AD_SEL, AD_OUT, AD_OE
  );
endinterface

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Loadable 8-bit down-counter shared by every bus phase; done marks the last
// cycle of the phase that was loaded.
module rtc_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign done = (cnt_q == 8'd1);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Turns a single-register menu request into one multiplexed address/data cycle
// on the external RTC and pulses FRW when it completes.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned TPULSE = TPULSE_DEF,
  parameter int unsigned TGAP   = TGAP_DEF
) (
  input logic           CLK,
  input logic           RST,
  rtc_bus_ctrl_if.slave bus
);

  localparam logic [7:0] TPulseW = 8'(TPULSE);
  localparam logic [7:0] TGapW   = 8'(TGAP);

  logic [2:0] state_q, state_d;
  rtc_req_t   req_q, req_d;
  logic       accept;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_done;
  logic       capture;

  logic       cs_q, cs_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       sel_q, sel_d;
  logic       oe_q, oe_d;
  logic [7:0] out_q, out_d;
  logic       frw_q, frw_d;
  logic       busy_q, busy_d;
  logic [7:0] rdata_q;
  logic [2:0] rdir_q;

  rtc_phase_timer u_timer (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = TPulseW;
    accept   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.Acceso) begin
          accept   = 1'b1;
          state_d  = StAddr;
          tmr_load = 1'b1;
          tmr_val  = TPulseW;
        end
      end
      StAddr: begin
        if (tmr_done) begin
          state_d  = StGap1;
          tmr_load = 1'b1;
          tmr_val  = TGapW;
        end
      end
      StGap1: begin
        if (tmr_done) begin
          state_d  = StData;
          tmr_load = 1'b1;
          tmr_val  = TPulseW;
        end
      end
      StData: begin
        if (tmr_done) begin
          state_d  = StGap2;
          tmr_load = 1'b1;
          tmr_val  = TGapW;
        end
      end
      StGap2: begin
        if (tmr_done) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The request is frozen at accept; later input changes are ignored.
  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d = '{mod: bus.Mod, dir: bus.DIR, wdata: bus.DATO_W};
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    sel_d  = 1'b1;
    oe_d   = 1'b0;
    out_d  = out_q;
    case (state_d)
      StAddr: begin
        sel_d = 1'b0;
        cs_d  = 1'b0;
        wr_d  = 1'b0;
        oe_d  = 1'b1;
        out_d = rtc_addr(req_d.dir);
      end
      StGap1: begin
        sel_d = 1'b0;
        oe_d  = 1'b1;
        out_d = rtc_addr(req_d.dir);
      end
      StData: begin
        cs_d = 1'b0;
        if (req_d.mod) begin
          wr_d  = 1'b0;
          oe_d  = 1'b1;
          out_d = req_d.wdata;
        end else begin
          rd_d = 1'b0;
        end
      end
      default: ;
    endcase
    frw_d  = (state_d == StDone);
    busy_d = (state_d != StIdle);
  end

  // Read data is taken on the final strobe cycle, when the RTC output is settled.
  assign capture = (state_q == StData) && tmr_done && !req_q.mod;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      req_q   <= '0;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      sel_q   <= 1'b1;
      oe_q    <= 1'b0;
      out_q   <= 8'd0;
      frw_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 8'd0;
      rdir_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      frw_q   <= frw_d;
      busy_q  <= busy_d;
      if (capture) begin
        rdata_q <= bus.AD_IN;
        rdir_q  <= req_q.dir;
      end
    end
  end

  assign bus.CS_n   = cs_q;
  assign bus.RD_n   = rd_q;
  assign bus.WR_n   = wr_q;
  assign bus.AD_SEL = sel_q;
  assign bus.AD_OE  = oe_q;
  assign bus.AD_OUT = out_q;
  assign bus.FRW    = frw_q;
  assign bus.BUSY   = busy_q;
  assign bus.DATO_R = rdata_q;
  assign bus.DIR_R  = rdir_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: two instances (default and 1/1 timing) checked each
// cycle against a transaction-offset model, plus literal spot checks.
module tb_rtc_bus_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done1    = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] reg_addr(input logic [2:0] d);
    if (d == 3'd0) return 8'h00;
    if (d == 3'd7) return 8'hF0;
    return 8'h20 + 8'(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int TP  = (g == 0) ? 4 : 1;
    localparam int TG  = (g == 0) ? 4 : 1;
    localparam int LEN = 2 * (TP + TG) + 1;

    rtc_bus_ctrl_if bus ();

    rtc_bus_ctrl #(.TPULSE(TP), .TGAP(TG)) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
    );

    // Model: t is the 1-based cycle index inside the current transaction.
    bit         active = 1'b0;
    int         t      = 0;
    logic       mm     = 1'b0;
    logic [2:0] md     = 3'd0;
    logic [7:0] mw     = 8'd0;
    logic [7:0] mr     = 8'd0;
    logic [2:0] mdr    = 3'd0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        active <= 1'b0;
        t      <= 0;
        mr     <= 8'd0;
        mdr    <= 3'd0;
      end else if (!active) begin
        if (bus.Acceso === 1'b1) begin
          active <= 1'b1;
          t      <= 1;
          mm     <= bus.Mod;
          md     <= bus.DIR;
          mw     <= bus.DATO_W;
        end
      end else if (t == LEN) begin
        active <= 1'b0;
      end else begin
        if (t == 2 * TP + TG && !mm) begin
          mr  <= bus.AD_IN;
          mdr <= md;
        end
        t <= t + 1;
      end
    end

    always @(negedge clk) begin : cmp
      logic e_cs, e_rd, e_wr, e_sel, e_oe, e_frw;
      logic [7:0] e_out;
      e_cs = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_sel = 1'b1; e_oe = 1'b0; e_frw = 1'b0;
      e_out = 8'd0;
      if (active) begin
        if (t <= TP) begin
          e_sel = 1'b0; e_cs = 1'b0; e_wr = 1'b0; e_oe = 1'b1; e_out = reg_addr(md);
        end else if (t <= TP + TG) begin
          e_sel = 1'b0; e_oe = 1'b1; e_out = reg_addr(md);
        end else if (t <= 2 * TP + TG) begin
          e_cs = 1'b0;
          if (mm) begin
            e_wr = 1'b0; e_oe = 1'b1; e_out = mw;
          end else begin
            e_rd = 1'b0;
          end
        end else if (t == LEN) begin
          e_frw = 1'b1;
        end
      end
      check($sformatf("dut%0d ctrl{frw,busy,cs,rd,wr,sel,oe}", g),
            {bus.FRW, bus.BUSY, bus.CS_n, bus.RD_n, bus.WR_n, bus.AD_SEL, bus.AD_OE},
            {e_frw, active, e_cs, e_rd, e_wr, e_sel, e_oe});
      if (e_oe) check($sformatf("dut%0d ad_out", g), bus.AD_OUT, e_out);
      check($sformatf("dut%0d {dir_r,dato_r}", g), {bus.DIR_R, bus.DATO_R}, {mdr, mr});
    end
  end

  task automatic start0(input logic mod, input logic [2:0] dir, input logic [7:0] wd);
    @(negedge clk);
    u[0].bus.Acceso = 1'b1; u[0].bus.Mod = mod; u[0].bus.DIR = dir; u[0].bus.DATO_W = wd;
    @(negedge clk);
    u[0].bus.Acceso = 1'b0;
  endtask

  // Default-timing instance: directed tests, random traffic, then async reset.
  initial begin
    logic [7:0] addrs [7];
    int         last_frw;
    bit         seen;
    addrs = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'hF0};
    u[0].bus.Acceso = 1'b0; u[0].bus.Mod = 1'b0; u[0].bus.DIR = 3'd0;
    u[0].bus.DATO_W = 8'd0; u[0].bus.AD_IN = 8'd0;
    repeat (3) @(negedge clk);
    check("reset {cs,rd,wr,sel,oe,busy,frw}",
          {u[0].bus.CS_n, u[0].bus.RD_n, u[0].bus.WR_n, u[0].bus.AD_SEL, u[0].bus.AD_OE,
           u[0].bus.BUSY, u[0].bus.FRW}, 7'b1111000);
    check("reset ad_out/dato_r", {u[0].bus.AD_OUT, u[0].bus.DATO_R}, 16'h0000);
    rst_n = 1'b1;

    // Write DIR=2 / 0x45; returns in cycle k+1.
    start0(1'b1, 3'd2, 8'h45);
    check("wr addr phase {ad_out,sel,wr}", {u[0].bus.AD_OUT, u[0].bus.AD_SEL, u[0].bus.WR_n},
          {8'h22, 2'b00});
    repeat (8) @(negedge clk);
    check("wr data phase {ad_out,sel,wr}", {u[0].bus.AD_OUT, u[0].bus.AD_SEL, u[0].bus.WR_n},
          {8'h45, 2'b10});
    repeat (7) @(negedge clk);
    check("wr frw k+16", u[0].bus.FRW, 1'b0);
    @(negedge clk);
    check("wr frw k+17", u[0].bus.FRW, 1'b1);
    check("wr dato_r unchanged", {u[0].bus.DIR_R, u[0].bus.DATO_R}, 11'd0);

    // Read DIR=6 with 0x16 on the bus.
    u[0].bus.AD_IN = 8'h16;
    start0(1'b0, 3'd6, 8'h00);
    repeat (8) @(negedge clk);
    check("rd data {rd,oe}", {u[0].bus.RD_n, u[0].bus.AD_OE}, 2'b00);
    repeat (4) @(negedge clk);
    check("rd captured {dir_r,dato_r}", {u[0].bus.DIR_R, u[0].bus.DATO_R}, {3'd6, 8'h16});
    repeat (4) @(negedge clk);
    check("rd frw k+17", u[0].bus.FRW, 1'b1);

    // Inputs changed after accept must not leak onto the bus.
    start0(1'b1, 3'd3, 8'hA5);
    @(negedge clk);
    u[0].bus.DIR = 3'd5; u[0].bus.DATO_W = 8'h11;
    check("midchange addr", u[0].bus.AD_OUT, 8'h23);
    repeat (7) @(negedge clk);
    check("midchange data", u[0].bus.AD_OUT, 8'hA5);
    repeat (8) @(negedge clk);
    check("midchange frw", u[0].bus.FRW, 1'b1);

    // Acceso held high: back-to-back transactions, DIR stepped after each FRW.
    @(negedge clk);
    u[0].bus.Acceso = 1'b1; u[0].bus.Mod = 1'b1; u[0].bus.DIR = 3'd1;
    u[0].bus.DATO_W = 8'($urandom);
    last_frw = 0;
    for (int i = 0; i < 7; i++) begin
      seen = 1'b0;
      for (int w = 0; w < 40 && !seen; w++) begin
        @(negedge clk);
        if (u[0].bus.AD_SEL == 1'b0 && u[0].bus.CS_n == 1'b0) seen = 1'b1;
      end
      check($sformatf("b2b addr %0d", i), seen ? u[0].bus.AD_OUT : 8'hXX, addrs[i]);
      seen = 1'b0;
      for (int w = 0; w < 40 && !seen; w++) begin
        @(negedge clk);
        if (u[0].bus.FRW == 1'b1) seen = 1'b1;
      end
      check($sformatf("b2b frw seen %0d", i), seen, 1'b1);
      if (i > 0) check($sformatf("b2b period %0d", i), cyc - last_frw, 18);
      last_frw = cyc;
      if (i < 6) u[0].bus.DIR = 3'(i + 2);
    end
    u[0].bus.Acceso = 1'b0;

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      u[0].bus.Acceso = ($urandom_range(0, 3) == 0);
      u[0].bus.Mod    = 1'($urandom);
      u[0].bus.DIR    = 3'($urandom);
      u[0].bus.DATO_W = 8'($urandom);
      u[0].bus.AD_IN  = 8'($urandom);
    end
    u[0].bus.Acceso = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 40 && !seen; w++) begin
      @(negedge clk);
      if (u[0].bus.BUSY == 1'b0) seen = 1'b1;
    end
    check("idle before reset test", seen, 1'b1);

    // Asynchronous reset in the middle of a write data phase.
    start0(1'b1, 3'd2, 8'h99);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async reset {cs,wr,oe,busy}",
             {u[0].bus.CS_n, u[0].bus.WR_n, u[0].bus.AD_OE, u[0].bus.BUSY}, 4'b1100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (u[0].bus.FRW !== 1'b0 || u[0].bus.BUSY !== 1'b0) seen = 1'b1;
    end
    check("no frw/busy after reset", seen, 1'b0);

    seen = done1;
    for (int w = 0; w < 3000 && !seen; w++) begin
      @(negedge clk);
      seen = done1;
    end
    check("dut1 stimulus finished", seen, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // TPULSE=1/TGAP=1 instance.
  initial begin
    u[1].bus.Acceso = 1'b0; u[1].bus.Mod = 1'b0; u[1].bus.DIR = 3'd0;
    u[1].bus.DATO_W = 8'd0; u[1].bus.AD_IN = 8'd0;
    wait (rst_n);
    @(negedge clk);
    @(negedge clk);
    u[1].bus.Acceso = 1'b1; u[1].bus.Mod = 1'b1; u[1].bus.DIR = 3'd4; u[1].bus.DATO_W = 8'h3C;
    @(negedge clk);
    u[1].bus.Acceso = 1'b0;
    check("short addr", u[1].bus.AD_OUT, 8'h24);
    repeat (3) @(negedge clk);
    check("short frw k+4", u[1].bus.FRW, 1'b0);
    @(negedge clk);
    check("short frw k+5", u[1].bus.FRW, 1'b1);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      u[1].bus.Acceso = ($urandom_range(0, 2) != 0);
      u[1].bus.Mod    = 1'($urandom);
      u[1].bus.DIR    = 3'($urandom);
      u[1].bus.DATO_W = 8'($urandom);
      u[1].bus.AD_IN  = 8'($urandom);
    end
    done1 = 1'b1;
  end

endmodule

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
- Responder side of the menu/RTC handshake. It accepts a single-register access request: Acceso is the strobe, Mod selects write (1) or read (0), and DIR gives the register index.
- Each request becomes one Intel-style multiplexed address/data bus cycle on the external RTC. Completion is signalled by a one-cycle FRW pulse.
- Sits between the menu FSMs and the RTC pins. The FPGA top level owns the tristate pad; this block drives AD_OUT/AD_OE and reads AD_IN.

Parameters:
- TPULSE, 4, number of CLK cycles CS_n plus the RD_n/WR_n strobe is held low in each phase; legal range 1..255.
- TGAP, 4, number of CLK cycles of strobe-inactive gap after each phase; legal range 1..255.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-low reset.
- Acceso  input  1  request; sampled only in IDLE.
- Mod  input  1  1 = write, 0 = read.
- DIR  input  3  register index, 0..7.
- DATO_W  input  8  write data.
- FRW  output  1  one-cycle pulse at transaction end.
- BUSY  output  1  high from request accept until FRW inclusive.
- DATO_R  output  8  last read data.
- DIR_R  output  3  index DATO_R belongs to.
- CS_n  output  1  RTC chip select.
- RD_n  output  1  RTC read strobe.
- WR_n  output  1  RTC write strobe.
- AD_SEL  output  1  RTC A/D line: 0 = address phase, 1 = data phase.
- AD_OUT  output  8  value driven onto the bus.
- AD_OE  output  1  bus output enable.
- AD_IN  input  8  bus sample.

Behaviour:
- Reset (RST low, asynchronous, takes effect immediately even mid-transaction): state IDLE; CS_n=1, RD_n=1, WR_n=1, AD_SEL=1, AD_OE=0, AD_OUT=0, FRW=0, BUSY=0, DATO_R=0, DIR_R=0; phase counter = 0.
- All outputs are registered.
- States: IDLE, ADDR, GAP1, DATA, GAP2, DONE. An 8-bit phase counter counts down within each state.
- IDLE: if Acceso=1 at a rising edge, latch Mod, DIR, DATO_W; load the counter with TPULSE; go to ADDR. Otherwise stay in IDLE.
- ADDR (TPULSE cycles):
  - AD_SEL=0, CS_n=0, WR_n=0 (the address is always written).
  - AD_OE=1, AD_OUT = ADDR_MAP[DIR latched].
  - Then load TGAP and go to GAP1.
- GAP1 (TGAP cycles): CS_n=1, WR_n=1; AD_OE stays 1 with the address held; AD_SEL=0. Then go to DATA.
- DATA (TPULSE cycles):
  - AD_SEL=1, CS_n=0.
  - Write: WR_n=0, AD_OE=1, AD_OUT = latched DATO_W.
  - Read: RD_n=0, AD_OE=0. AD_IN is sampled into DATO_R (and the latched DIR into DIR_R) on the last DATA cycle only.
- GAP2 (TGAP cycles): CS_n=1, RD_n=1, WR_n=1; AD_OE=0; AD_SEL=1. Then go to DONE.
- DONE (1 cycle): FRW=1, then return to IDLE.
- Latency: if Acceso is sampled at edge k, FRW is high in cycle k+1+2*(TPULSE+TGAP). With defaults that is k+17.
- Acceso held high continuously: a new transaction starts on the first edge after DONE. The IDLE dwell is exactly 1 cycle.
- Changes to Acceso, Mod, DIR or DATO_W after accept are ignored until the next IDLE.
- On a write, DATO_R and DIR_R are unchanged.
- Any DIR 0..7 is legal; there is no wrap or invalid index.
- Bus contention rule: AD_OE=0 in every cycle where RD_n=0 and in every reset cycle. RD_n and WR_n are never low simultaneously.

Decomposition:
- Package rtc_pkg:
  - ADDR_MAP, an 8-entry by 8-bit table:
    - 0 = 0x00 (control)
    - 1 = 0x21 (seconds)
    - 2 = 0x22 (minutes)
    - 3 = 0x23 (hours)
    - 4 = 0x24 (day)
    - 5 = 0x25 (month)
    - 6 = 0x26 (year)
    - 7 = 0xF0 (command/transfer)
  - State encoding constants.
  - Default TPULSE and TGAP.
- One natural sub-module: rtc_phase_timer, a loadable 8-bit down-counter with a done flag, reused for every phase.

Test Plan:
- Reset: assert RST low mid-DATA of a write → same cycle CS_n=1, WR_n=1, AD_OE=0, BUSY=0; after release, state is IDLE and FRW stays 0.
- Write DIR=2, DATO_W=0x45, Mod=1, Acceso pulsed at edge k → ADDR shows AD_OUT=0x22 with AD_SEL=0 and WR_n=0 for 4 cycles; DATA shows AD_OUT=0x45 with WR_n=0 for 4 cycles; FRW at k+17; DATO_R unchanged.
- Read DIR=6 with AD_IN=0x16 during DATA → RD_n=0 for 4 cycles with AD_OE=0; DATO_R=0x16 and DIR_R=6 after the last DATA cycle; FRW at k+17.
- Acceso held high, DIR stepping 1..7 after each FRW → seven back-to-back transactions with 1-cycle IDLE between them; addresses 0x21..0x26 then 0xF0.
- DIR/DATO_W changed mid-transaction (DIR 3→5) → bus still shows 0x23 and the original data.
- TPULSE=1, TGAP=1 → FRW at k+5; the RD_n/AD_OE exclusion holds every cycle.
